// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end sharing one 16x16 unsigned multiplier
// among N requesters.
//
// Pipeline: the grant selects one requester's operands into stage A, the
// combinational multiplier works on stage A, and stage B holds the product
// and requester tag until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  [N]      requester i offers an operand pair
//   req_x      [N*16]   packed X operands, requester i at [16i+15:16i]
//   req_y      [N*16]   packed Y operands, same packing
//   req_ready  [N]      one-hot grant, combinational from req_valid/ptr/a_free
//   rsp_valid           response register holds a product
//   rsp_p      [32]     unsigned product X*Y
//   rsp_id     [IDW]    index of the requester that produced rsp_p
//   rsp_ready           consumer accepts the response

// MUL: purely combinational 16x16 unsigned multiplier; full 32-bit result.
module MUL (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    output logic [31:0] p_o
);
    assign p_o = {16'h0000, x_i} * {16'h0000, y_i};
endmodule

module mul_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N*16-1:0]   req_x,
    input  logic [N*16-1:0]   req_y,
    output logic [N-1:0]      req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_p,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready
);

    // Stage A: operand register
    logic           a_valid_q;
    logic [15:0]    a_x_q;
    logic [15:0]    a_y_q;
    logic [IDW-1:0] a_id_q;

    // Stage B: response register
    logic           rsp_valid_q;
    logic [31:0]    rsp_p_q;
    logic [IDW-1:0] rsp_id_q;

    // Round-robin pointer: highest-priority requester
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    logic           b_adv;
    logic           a_free;
    logic [31:0]    mul_p;

    logic [N-1:0]   rv_rot;
    logic           found;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;
    logic [15:0]    sel_x;
    logic [15:0]    sel_y;

    assign b_adv  = a_valid_q & (~rsp_valid_q | rsp_ready);
    assign a_free = ~a_valid_q | b_adv;

    MUL u_mul (
        .x_i (a_x_q),
        .y_i (a_y_q),
        .p_o (mul_p)
    );

    // Rotate the request vector so bit 0 is the requester at ptr; the first
    // set bit gives the offset from ptr, which is then wrapped back mod N.
    always_comb begin
        rv_rot = N'({req_valid, req_valid} >> ptr_q);
        found  = 1'b0;
        off    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && ((rv_rot >> i) & N'(1)) != '0) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end

        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= (IDW+1)'(N)) begin
            gnt_id = IDW'(sum - (IDW+1)'(N));
        end else begin
            gnt_id = sum[IDW-1:0];
        end

        gnt_any   = found & a_free & ~rst;
        req_ready = gnt_any ? (N'(1) << gnt_id) : '0;

        // Explicit wrap so non-power-of-two N never points past N-1
        if (gnt_id == IDW'(N-1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_id + IDW'(1);
        end

        sel_x = 16'(req_x >> {gnt_id, 4'b0000});
        sel_y = 16'(req_y >> {gnt_id, 4'b0000});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q   <= 1'b0;
            a_x_q       <= '0;
            a_y_q       <= '0;
            a_id_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            if (b_adv) begin
                rsp_valid_q <= 1'b1;
                rsp_p_q     <= mul_p;
                rsp_id_q    <= a_id_q;
            end else if (rsp_ready && rsp_valid_q) begin
                rsp_valid_q <= 1'b0;
            end

            if (a_free) begin
                if (gnt_any) begin
                    a_valid_q <= 1'b1;
                    a_x_q     <= sel_x;
                    a_y_q     <= sel_y;
                    a_id_q    <= gnt_id;
                    ptr_q     <= ptr_d;
                end else begin
                    a_valid_q <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;

endmodule
